// File: rtl/gated_pipe_pkg.sv
// Shared types and constants for the gated_pipe block.
// The per-channel load counter is built only when GATED_PIPE_CNT_EN is defined.
package gated_pipe_pkg;

  typedef enum logic {
    MODE_HOLD   = 1'b0,
    MODE_INVERT = 1'b1
  } mode_e;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/gated_pipe_ch.sv
// One channel of gated_pipe: gated stage 0, free-running shift stages, and
// a saturating load counter when GATED_PIPE_CNT_EN is defined.
module gated_pipe_ch
  import gated_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out,
  output logic             out_vld
`ifdef GATED_PIPE_CNT_EN
  ,
  output logic [CNT_W-1:0] load_cnt
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      if (enable) begin
        data_q[0] <= a;
      end else if (mode_sel == MODE_INVERT) begin
        data_q[0] <= ~a;
      end else begin
        data_q[0] <= data_q[0];
      end
      vld_q[0] <= enable | mode;
      // Later stages never stall; held data keeps draining with valid low.
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign out     = data_q[DEPTH-1];
  assign out_vld = vld_q[DEPTH-1];

`ifdef GATED_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Only true loads count; INVERT captures leave the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign load_cnt = cnt_q;
`endif

endmodule

// File: rtl/gated_pipe.sv
// Multi-channel gated pipeline: CH independent gated_pipe_ch instances.
// Define GATED_PIPE_CNT_EN to add the per-channel load_cnt output.
module gated_pipe
  import gated_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       enable,
  input  logic [CH-1:0]       mode,
  input  logic [CH*WIDTH-1:0] a,
  output logic [CH*WIDTH-1:0] out,
  output logic [CH-1:0]       out_vld
`ifdef GATED_PIPE_CNT_EN
  ,
  output logic [CH*CNT_W-1:0] load_cnt
`endif
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    gated_pipe_ch #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable[i]),
      .mode    (mode[i]),
      .a       (a[i*WIDTH +: WIDTH]),
      .out     (out[i*WIDTH +: WIDTH]),
      .out_vld (out_vld[i])
`ifdef GATED_PIPE_CNT_EN
      ,
      .load_cnt(load_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_gated_pipe.sv
// Directed self-checking bench for gated_pipe: default build plus two
// parameter-sweep instances; counter checks when GATED_PIPE_CNT_EN is defined.
module tb_gated_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Main instance: WIDTH=8, CH=4, DEPTH=2
  logic [3:0]  en, md;
  logic [31:0] a;
  logic [31:0] out;
  logic [3:0]  vld;
  logic [63:0] cnt;

  // Sweep instance: WIDTH=1, CH=1, DEPTH=1
  logic s_en, s_md, s_a, s_out, s_vld;
  logic [15:0] s_cnt;

  // Sweep instance: WIDTH=64, CH=16, DEPTH=8
  logic [15:0]   b_en, b_md;
  logic [1023:0] b_a;
  logic [1023:0] b_out;
  logic [15:0]   b_vld;
  logic [255:0]  b_cnt;

  gated_pipe u_dut (
    .clk(clk), .rst(rst), .enable(en), .mode(md), .a(a),
    .out(out), .out_vld(vld)
`ifdef GATED_PIPE_CNT_EN
    , .load_cnt(cnt)
`endif
  );

  gated_pipe #(.WIDTH(1), .CH(1), .DEPTH(1)) u_small (
    .clk(clk), .rst(rst), .enable(s_en), .mode(s_md), .a(s_a),
    .out(s_out), .out_vld(s_vld)
`ifdef GATED_PIPE_CNT_EN
    , .load_cnt(s_cnt)
`endif
  );

  gated_pipe #(.WIDTH(64), .CH(16), .DEPTH(8)) u_big (
    .clk(clk), .rst(rst), .enable(b_en), .mode(b_md), .a(b_a),
    .out(b_out), .out_vld(b_vld)
`ifdef GATED_PIPE_CNT_EN
    , .load_cnt(b_cnt)
`endif
  );

`ifndef GATED_PIPE_CNT_EN
  assign cnt   = '0;
  assign s_cnt = '0;
  assign b_cnt = '0;
`endif

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 4'($urandom);
    md  = 4'($urandom);
    a   = $urandom;
    tick(2);
    n_cmp++;
    if (out !== 32'h0 || vld !== 4'h0) begin
      n_err++;
      $display("FAIL reset_out: out=%h vld=%b, want 00000000/0000", out, vld);
    end
`ifdef GATED_PIPE_CNT_EN
    n_cmp++;
    if (cnt !== 64'h0) begin
      n_err++;
      $display("FAIL reset_cnt: load_cnt=%h, want 0", cnt);
    end
`endif
    rst = 1'b0;
    en  = 4'b0001;
    md  = 4'b0000;
    a   = 32'h0000_005A;
    tick(1);
    en  = 4'b0000;
    tick(1);
    n_cmp++;
    if (out !== 32'h0000_005A || vld !== 4'b0001) begin
      n_err++;
      $display("FAIL first_load: out=%h vld=%b, want 0000005a/0001", out, vld);
    end
  endtask

  task automatic test_invert();
    en = 4'b0000;
    md = 4'b0010;
    a  = 32'h0000_0F00;
    tick(2);
    n_cmp++;
    if (out !== 32'h0000_F05A || vld !== 4'b0010) begin
      n_err++;
      $display("FAIL invert: out=%h vld=%b, want 0000f05a/0010", out, vld);
    end
  endtask

  task automatic test_hold();
    md = 4'b0000;
    en = 4'b0100;
    a  = 32'h0033_0000;
    tick(1);
    en = 4'b0000;
    a  = 32'h00FF_0000;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      n_cmp++;
      if (out[23:16] !== 8'h33 || vld[2] !== (k == 1)) begin
        n_err++;
        $display("FAIL hold_%0d: out2=%h vld2=%b, want 33/%b", k, out[23:16], vld[2], k == 1);
      end
    end
    n_cmp++;
    if (out !== 32'h0033_F05A || vld !== 4'b0000) begin
      n_err++;
      $display("FAIL hold_all: out=%h vld=%b, want 0033f05a/0000", out, vld);
    end
  endtask

  task automatic test_all_channels();
    en = 4'b1111;
    md = 4'b0000;
    a  = 32'h4433_2211;
    tick(2);
    n_cmp++;
    if (out !== 32'h4433_2211 || vld !== 4'b1111) begin
      n_err++;
      $display("FAIL all_en: out=%h vld=%b, want 44332211/1111", out, vld);
    end
    en = 4'b1001;
    md = 4'b0010;
    a  = 32'hAABB_CCDD;
    tick(1);
    n_cmp++;
    if (out !== 32'h4433_2211 || vld !== 4'b1111) begin
      n_err++;
      $display("FAIL latency_early: out=%h vld=%b, want 44332211/1111", out, vld);
    end
    tick(1);
    n_cmp++;
    if (out !== 32'hAA33_33DD || vld !== 4'b1011) begin
      n_err++;
      $display("FAIL mixed: out=%h vld=%b, want aa3333dd/1011", out, vld);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out !== 32'h0 || vld !== 4'h0) begin
      n_err++;
      $display("FAIL reset_async: out=%h vld=%b, want 00000000/0000", out, vld);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 4'b0000;
    md  = 4'b0000;
    tick(1);
    n_cmp++;
    if (out !== 32'h0 || vld !== 4'h0) begin
      n_err++;
      $display("FAIL reset_release: out=%h vld=%b, want 00000000/0000", out, vld);
    end
  endtask

  task automatic test_sweep_small();
    logic [1:0] vec_in  [4];
    logic [2:0] vec_exp [4];
    // {en, md, a} -> {out, vld}
    vec_in[0] = 2'b10; vec_exp[0] = 3'b1_1_1;
    vec_in[1] = 2'b01; vec_exp[1] = 3'b1_0_1;
    vec_in[2] = 2'b00; vec_exp[2] = 3'b0_0_0;
    vec_in[3] = 2'b01; vec_exp[3] = 3'b0_1_1;
    for (int k = 0; k < 4; k++) begin
      s_en = vec_in[k][1];
      s_md = vec_in[k][0];
      s_a  = vec_exp[k][2];
      tick(1);
      n_cmp++;
      if (s_out !== vec_exp[k][1] || s_vld !== vec_exp[k][0]) begin
        n_err++;
        $display("FAIL small_%0d: out=%b vld=%b, want %b/%b", k, s_out, s_vld,
                 vec_exp[k][1], vec_exp[k][0]);
      end
    end
    s_en = 1'b0;
    s_md = 1'b0;
  endtask

  task automatic test_sweep_big();
    logic [63:0] m_prev [16];
    logic [63:0] m_new  [16];
    logic [15:0] v_new;
    for (int j = 0; j < 16; j++) m_prev[j] = '0;
    for (int r = 0; r < 3; r++) begin
      b_en = 16'($urandom);
      b_md = 16'($urandom);
      for (int j = 0; j < 16; j++) begin
        b_a[j*64 +: 64] = {$urandom, $urandom};
        if (b_en[j])      m_new[j] = b_a[j*64 +: 64];
        else if (b_md[j]) m_new[j] = ~b_a[j*64 +: 64];
        else              m_new[j] = m_prev[j];
      end
      v_new = b_en | b_md;
      tick(1);
      b_en = '0;
      b_md = '0;
      tick(6);
      for (int j = 0; j < 16; j++) begin
        n_cmp++;
        if (b_out[j*64 +: 64] !== m_prev[j] || b_vld[j] !== 1'b0) begin
          n_err++;
          $display("FAIL big_early r%0d ch%0d: out=%h vld=%b, want %h/0", r, j,
                   b_out[j*64 +: 64], b_vld[j], m_prev[j]);
        end
      end
      tick(1);
      for (int j = 0; j < 16; j++) begin
        n_cmp++;
        if (b_out[j*64 +: 64] !== m_new[j] || b_vld[j] !== v_new[j]) begin
          n_err++;
          $display("FAIL big_out r%0d ch%0d: out=%h vld=%b, want %h/%b", r, j,
                   b_out[j*64 +: 64], b_vld[j], m_new[j], v_new[j]);
        end
      end
      tick(8);
      for (int j = 0; j < 16; j++) m_prev[j] = m_new[j];
    end
  endtask

`ifdef GATED_PIPE_CNT_EN
  task automatic test_counter();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en  = 4'b0001;
    md  = 4'b0000;
    tick(10);
    n_cmp++;
    if (cnt !== 64'h0000_0000_0000_000A) begin
      n_err++;
      $display("FAIL cnt_10: load_cnt=%h, want 000000000000000a", cnt);
    end
    tick(65524);
    n_cmp++;
    if (cnt[15:0] !== 16'hFFFE) begin
      n_err++;
      $display("FAIL cnt_65534: cnt0=%h, want fffe", cnt[15:0]);
    end
    tick(1);
    n_cmp++;
    if (cnt[15:0] !== 16'hFFFF) begin
      n_err++;
      $display("FAIL cnt_65535: cnt0=%h, want ffff", cnt[15:0]);
    end
    tick(4465);
    n_cmp++;
    if (cnt[15:0] !== 16'hFFFF || cnt[63:16] !== 48'h0) begin
      n_err++;
      $display("FAIL cnt_sat: load_cnt=%h, want 000000000000ffff", cnt);
    end
    en = 4'b0000;
    md = 4'b0011;
    tick(20);
    n_cmp++;
    if (cnt !== 64'h0000_0000_0000_FFFF) begin
      n_err++;
      $display("FAIL cnt_invert: load_cnt=%h, want 000000000000ffff", cnt);
    end
  endtask
`endif

  initial begin
    s_en = 1'b0; s_md = 1'b0; s_a = 1'b0;
    b_en = '0;   b_md = '0;   b_a = '0;
    test_reset();
    test_invert();
    test_hold();
    test_all_channels();
    test_reset_mid();
    test_sweep_small();
    test_sweep_big();
`ifdef GATED_PIPE_CNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gated_pipe.md
GATED_PIPE -- requirements
Module: gated_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (legal range 1..64).
REQ-002 Parameter CH, default 4, number of independent channels (legal range 1..16).
REQ-003 Parameter DEPTH, default 2, pipeline stages per channel (legal range 1..8).
REQ-004 Port clk  input  1  single clock; all state changes on posedge clk.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port enable  input  CH  per-channel load enable.
REQ-007 Port mode  input  CH  per-channel disabled-behaviour select (0 = HOLD, 1 = INVERT).
REQ-008 Port a  input  CH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port out  output  CH*WIDTH  per-channel pipeline output, same packing as a.
REQ-010 Port out_vld  output  CH  per-channel output-valid flag.
REQ-011 Port load_cnt  output  CH*16  per-channel load counter, present only under GATED_PIPE_CNT_EN.

Function
REQ-012 Stage 0 of channel i SHALL capture a[i] when enable[i]=1.
REQ-013 Stage 0 SHALL capture ~a[i] when enable[i]=0 and mode[i]=1.
REQ-014 Stage 0 SHALL hold its value when enable[i]=0 and mode[i]=0.
REQ-015 Stage-0 valid SHALL be (enable[i] | mode[i]), registered with the stage-0 data.
REQ-016 Stages 1..DEPTH-1 SHALL advance data and valid every cycle, with no stall.
REQ-017 out/out_vld SHALL be the last stage, so latency is exactly DEPTH cycles from the input sample to the output.
REQ-018 For DEPTH=1, out SHALL be stage 0 directly, with 1-cycle latency.
REQ-019 A held stage 0 SHALL propagate valid=0 while its held data still shifts down the stages, so out keeps the last data with out_vld=0.
REQ-020 Channels SHALL be fully independent; simultaneous enables on all channels are legal.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational input-to-output path.
REQ-022 There SHALL be no latches; every stage register is assigned on every clock path.

Reset
REQ-023 While rst=1, all stage data, valid bits and counters SHALL be 0, so out=0, out_vld=0 and load_cnt=0.
REQ-024 Reset asserted mid-stream SHALL clear in-flight data immediately, without waiting for clk.
REQ-025 The first capture after deassertion SHALL occur on the first posedge clk with rst=0.

Configuration
REQ-026 Macro GATED_PIPE_CNT_EN defined: per-channel 16-bit counter increments on each posedge where enable[i]=1 (INVERT loads are not counted).
REQ-027 The counter SHALL saturate at 16'hFFFF and not wrap.
REQ-028 Macro GATED_PIPE_CNT_EN undefined: the load_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package gated_pipe_pkg SHALL hold the mode_e enum (MODE_HOLD=0, MODE_INVERT=1), the constant CNT_W=16 and CNT_MAX.
REQ-030 Sub-module gated_pipe_ch (one channel: stage 0, pipeline, optional counter) SHALL be instantiated CH times in a generate loop.

Verification
REQ-031 Reset sequence: rst=1 with random inputs -> out=0, out_vld=0, load_cnt=0; rst=0 plus one clk with enable=1, a=8'h5A on ch0 -> after 2 clk (DEPTH=2), out[ch0]=8'h5A, out_vld[0]=1.
REQ-032 INVERT mode: ch1 with enable=0, mode=1, a=8'h0F -> after 2 clk, out[ch1]=8'hF0, out_vld[1]=1.
REQ-033 HOLD mode: ch2 loads 8'h33, then enable=0, mode=0, a=8'hFF for 5 clk -> out[ch2] stays 8'h33, out_vld[2]=0 from the 2nd clk after the hold starts.
REQ-034 Reset mid-stream: assert rst between clock edges while out_vld=1 -> out and out_vld go to 0 before the next posedge.
REQ-035 Counter (CNT_EN): 70000 consecutive enable=1 cycles -> load_cnt stays 16'hFFFF after saturation; INVERT cycles leave the count unchanged.
REQ-036 Parameter sweep: DEPTH=1, CH=1, WIDTH=1 and DEPTH=8, CH=16, WIDTH=64 -> latency equals DEPTH, and channels do not cross-talk under independent random enable/mode.
